// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU port C has fixed priority over DMA port D.
// Optional starvation guard for D under `DMEM_ARB_STARVE_EN`.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
    $error("dmem_arbiter: MAX_WAIT must be within 1..15");
  end

  logic              c_win;
  logic              d_win;
  logic              starve;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misaligned;

`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] wait_q;

  assign starve = d_req && (wait_q == 4'(MAX_WAIT));

  // Counts consecutive denied cycles of a pending D request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= 4'd0;
    end else if (d_req && !d_win) begin
      if (wait_q != 4'(MAX_WAIT)) wait_q <= wait_q + 4'd1;
    end else begin
      wait_q <= 4'd0;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Grants are forced low while reset is held so no strobe can leak out.
  assign d_win = !rst && d_req && (!c_req || starve);
  assign c_win = !rst && c_req && !d_win;
  assign c_gnt = c_win;
  assign d_gnt = d_win;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (c_win) begin
      sel_we    = c_we;
      sel_addr  = c_addr;
      sel_wdata = c_wdata;
    end else if (d_win) begin
      sel_we    = d_we;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end
  end

  assign misaligned = sel_addr[1:0] != 2'b00;
  assign mem_addr   = sel_addr;
  assign mem_wdata  = sel_wdata;
  assign mem_read   = (c_win || d_win) && !sel_we && !misaligned;
  assign mem_write  = (c_win || d_win) && sel_we && !misaligned;

  // Aligned writes leave rdata untouched; errors force it to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      c_err    <= 1'b0;
      c_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_win;
      c_err    <= c_win && misaligned;
      d_rvalid <= d_win;
      d_err    <= d_win && misaligned;
      if (c_win) begin
        if (misaligned)  c_rdata <= '0;
        else if (!c_we)  c_rdata <= mem_rdata;
      end
      if (d_win) begin
        if (misaligned)  d_rdata <= '0;
        else if (!d_we)  d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_c_rdata, exp_d_rdata;
  int          denied;
  int          vectors    = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment memory: combinational read, clocked write.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".c_gnt"}, 32'(c_gnt), 0);
    chk({tag, ".d_gnt"}, 32'(d_gnt), 0);
    chk({tag, ".mem_read"}, 32'(mem_read), 0);
    chk({tag, ".mem_write"}, 32'(mem_write), 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".c_rvalid"}, 32'(c_rvalid), 0);
    chk({tag, ".c_rdata"}, c_rdata, 0);
    chk({tag, ".d_rvalid"}, 32'(d_rvalid), 0);
    chk({tag, ".d_rdata"}, d_rdata, 0);
    exp_c_rdata = 0;
    exp_d_rdata = 0;
    denied      = 0;
  endtask

  // One arbitration cycle; called just after a falling edge, returns at the next one.
  task automatic cycle(input string tag,
                       input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    logic        eg_d, eg_c, we, mis, any;
    logic [31:0] a, wd;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    eg_d = dr && (!cr || (STARVE && denied == MAX_WAIT));
    eg_c = cr && !eg_d;
    any  = eg_c || eg_d;
    we   = eg_c ? cw : (eg_d ? dw : 1'b0);
    a    = eg_c ? ca : (eg_d ? da : 32'h0);
    wd   = eg_c ? cd : (eg_d ? dd : 32'h0);
    mis  = a[1:0] != 2'b00;
    #1;
    chk({tag, ".c_gnt"}, 32'(c_gnt), 32'(eg_c));
    chk({tag, ".d_gnt"}, 32'(d_gnt), 32'(eg_d));
    chk({tag, ".mem_read"}, 32'(mem_read), 32'(any && !we && !mis));
    chk({tag, ".mem_write"}, 32'(mem_write), 32'(any && we && !mis));
    chk({tag, ".mem_addr"}, mem_addr, a);
    chk({tag, ".mem_wdata"}, mem_wdata, wd);
    if (any) begin
      if (mis) begin
        if (eg_c) exp_c_rdata = 0; else exp_d_rdata = 0;
      end else if (we) begin
        ref_mem[a[7:2]] = wd;
      end else begin
        if (eg_c) exp_c_rdata = ref_mem[a[7:2]]; else exp_d_rdata = ref_mem[a[7:2]];
      end
    end
    if (dr && !eg_d) denied = (denied < MAX_WAIT) ? denied + 1 : denied;
    else             denied = 0;
    @(posedge clk);
    #1;
    chk({tag, ".c_rvalid"}, 32'(c_rvalid), 32'(eg_c));
    chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(eg_d));
    if (eg_c) chk({tag, ".c_err"}, 32'(c_err), 32'(mis));
    if (eg_d) chk({tag, ".d_err"}, 32'(d_err), 32'(mis));
    chk({tag, ".c_rdata"}, c_rdata, exp_c_rdata);
    chk({tag, ".d_rdata"}, d_rdata, exp_d_rdata);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[2]     = 32'hDEADBEEF;
    ref_mem[2] = 32'hDEADBEEF;

    // Reset held with a request pending: everything must be quiet.
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h8; c_wdata = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = 0;
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // First cycle out of reset: C read of preloaded word.
    cycle("c_read", 1, 0, 32'h8, 0, 0, 0, 0, 0);
    chk("c_read.rdata_value", c_rdata, 32'hDEADBEEF);

    // D write then D read with C idle.
    cycle("d_write", 0, 0, 0, 0, 1, 1, 32'h10, 32'h12345678);
    cycle("d_read", 0, 0, 0, 0, 1, 0, 32'h10, 0);
    chk("d_read.rdata_value", d_rdata, 32'h12345678);

    // Misaligned C write must not touch the word at 0x4.
    cycle("c_miswr", 1, 1, 32'h6, 32'hA5A5A5A5, 0, 0, 0, 0);
    chk("c_miswr.err_value", 32'(c_err), 1);
    chk("c_miswr.mem4", mem[1], ref_mem[1]);
    cycle("d_misrd", 0, 0, 0, 0, 1, 0, 32'h13, 0);

    // Continuous contention, then C drops.
    for (int i = 0; i < 10; i++)
      cycle("contend", 1, 0, 32'(i * 4), 0, 1, 0, 32'h20, 0);
    cycle("c_drop", 0, 0, 0, 0, 1, 0, 32'h20, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);

    // Reset mid-access: rvalid of a just-granted read is dropped.
    cycle("pre_rst", 1, 0, 32'h8, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst", 1, 0, 32'h10, 0, 1, 0, 32'h8, 0);

    for (int i = 0; i < 64; i++)
      chk("mem_final", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
